// File: rtl/fpu_shift_pkg.sv
// Shared types for the alignment shifter: shift mode encoding and the
// guard/round/sticky bundle that comes back from a logical right shift.
package fpu_shift_pkg;

  typedef enum logic [1:0] {
    MODE_LSR = 2'b00,
    MODE_LSL = 2'b01,
    MODE_ASR = 2'b10,
    MODE_ROR = 2'b11
  } shift_mode_e;

  typedef struct packed {
    logic guard;
    logic round;
    logic sticky;
  } grs_t;

endpackage

// File: rtl/shift_stage.sv
// One slice of the log shifter: applies levels [LVL_LO, LVL_HI) to an
// extended {data, guard, round} word plus sticky, then optionally registers it.
module shift_stage
  import fpu_shift_pkg::*;
#(
  parameter int WIDTH  = 23,
  parameter int TAG_W  = 4,
  parameter int AIN_W  = 8,
  parameter int LVL    = 5,
  parameter int LVL_LO = 0,
  parameter int LVL_HI = 5,
  parameter bit FIRST  = 1'b0,
  parameter bit REG    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              valid_i,
  input  logic [WIDTH+1:0]  ext_i,
  input  logic              sticky_i,
  input  logic [AIN_W-1:0]  amt_i,
  input  shift_mode_e       mode_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              valid_o,
  output logic [WIDTH+1:0]  ext_o,
  output logic              sticky_o,
  output logic [LVL-1:0]    amt_o,
  output shift_mode_e       mode_o,
  output logic [TAG_W-1:0]  tag_o
);

  localparam int EW = WIDTH + 2;

  logic [EW-1:0]    preExt;
  logic             preStk;
  logic [LVL-1:0]   preEff;
  logic [EW-1:0]    ext_d;
  logic             sticky_d;
  logic [WIDTH-1:0] fld;

  if (FIRST) begin : g_pre
    // Large amounts are settled here so the later levels only ever see
    // amounts that fit the level range without overflowing the word.
    logic [31:0] amtWide;
    always_comb begin
      amtWide = 32'(amt_i);
      preExt  = ext_i;
      preStk  = sticky_i;
      preEff  = LVL'(amtWide);
      case (mode_i)
        MODE_LSR: if (amtWide >= 32'(EW)) begin
          preExt = '0;
          preStk = |ext_i;
          preEff = '0;
        end
        MODE_LSL: if (amtWide >= 32'(WIDTH)) begin
          preExt = '0;
          preEff = '0;
        end
        MODE_ASR: if (amtWide >= 32'(WIDTH - 1)) begin
          preExt = {{WIDTH{ext_i[EW-1]}}, 2'b00};
          preEff = '0;
        end
        MODE_ROR: preEff = LVL'(amtWide % 32'(WIDTH));
        default: preEff = LVL'(amtWide);
      endcase
    end
  end else begin : g_pass
    assign preExt = ext_i;
    assign preStk = sticky_i;
    assign preEff = LVL'(amt_i);
  end

  always_comb begin
    ext_d    = preExt;
    sticky_d = preStk;
    fld      = '0;
    for (int k = LVL_LO; k < LVL_HI; k++) begin
      if (preEff[k]) begin
        fld = ext_d[EW-1:2];
        case (mode_i)
          MODE_LSR: begin
            sticky_d = sticky_d | (|(ext_d & ((EW'(1) << (1 << k)) - EW'(1))));
            ext_d    = ext_d >> (1 << k);
          end
          MODE_LSL: ext_d = {fld << (1 << k), 2'b00};
          MODE_ASR: ext_d = {WIDTH'($signed(fld) >>> (1 << k)), 2'b00};
          MODE_ROR: ext_d = {(fld >> ((1 << k) % WIDTH)) |
                             (fld << (WIDTH - ((1 << k) % WIDTH))), 2'b00};
          default: ext_d = preExt;
        endcase
      end
    end
  end

  if (REG) begin : g_reg
    logic             valid_q;
    logic [EW-1:0]    ext_q;
    logic             sticky_q;
    logic [LVL-1:0]   amt_q;
    shift_mode_e      mode_q;
    logic [TAG_W-1:0] tag_q;

    // The whole pipe advances together on en_i, so a stall freezes every slice.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q  <= 1'b0;
        ext_q    <= '0;
        sticky_q <= 1'b0;
        amt_q    <= '0;
        mode_q   <= MODE_LSR;
        tag_q    <= '0;
      end else if (en_i) begin
        valid_q  <= valid_i;
        ext_q    <= ext_d;
        sticky_q <= sticky_d;
        amt_q    <= preEff;
        mode_q   <= mode_i;
        tag_q    <= tag_i;
      end
    end

    assign valid_o  = valid_q;
    assign ext_o    = ext_q;
    assign sticky_o = sticky_q;
    assign amt_o    = amt_q;
    assign mode_o   = mode_q;
    assign tag_o    = tag_q;
  end else begin : g_comb
    assign valid_o  = valid_i;
    assign ext_o    = ext_d;
    assign sticky_o = sticky_d;
    assign amt_o    = preEff;
    assign mode_o   = mode_i;
    assign tag_o    = tag_i;
  end

endmodule

// File: rtl/align_shifter_pipe.sv
// Pipelined mantissa alignment shifter (LSR with GRS, LSL, ASR, ROR) whose
// log levels are spread over STAGES registered slices with a global stall.
module align_shifter_pipe
  import fpu_shift_pkg::*;
#(
  parameter int WIDTH   = 23,
  parameter int SHAMT_W = 8,
  parameter int STAGES  = 2,
  parameter int TAG_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shift_amount,
  input  logic [1:0]         mode,
  input  logic [TAG_W-1:0]   tag_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   data_out,
  output logic [2:0]         grs,
  output logic [TAG_W-1:0]   tag_out
);

  localparam int LVL = $clog2(WIDTH + 2);

  logic             stVld  [0:STAGES];
  logic [WIDTH+1:0] stExt  [0:STAGES];
  logic             stStk  [0:STAGES];
  logic [LVL-1:0]   stAmt  [1:STAGES];
  shift_mode_e      stMode [0:STAGES];
  logic [TAG_W-1:0] stTag  [0:STAGES];
  grs_t             grsOut;

  assign in_ready  = !out_valid || out_ready;

  assign stVld[0]  = in_valid;
  assign stExt[0]  = {data_in, 2'b00};
  assign stStk[0]  = 1'b0;
  assign stMode[0] = shift_mode_e'(mode);
  assign stTag[0]  = tag_in;

  // Slice s owns levels [s*LVL/STAGES, (s+1)*LVL/STAGES); slice 0 also saturates.
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LO = (s * LVL) / STAGES;
    localparam int HI = ((s + 1) * LVL) / STAGES;
    if (s == 0) begin : g_first
      shift_stage #(
        .WIDTH(WIDTH), .TAG_W(TAG_W), .AIN_W(SHAMT_W), .LVL(LVL),
        .LVL_LO(LO), .LVL_HI(HI), .FIRST(1'b1), .REG(1'b1)
      ) u_stage (
        .clk(clk), .rst(rst), .en_i(in_ready),
        .valid_i(stVld[s]), .ext_i(stExt[s]), .sticky_i(stStk[s]),
        .amt_i(shift_amount), .mode_i(stMode[s]), .tag_i(stTag[s]),
        .valid_o(stVld[s+1]), .ext_o(stExt[s+1]), .sticky_o(stStk[s+1]),
        .amt_o(stAmt[s+1]), .mode_o(stMode[s+1]), .tag_o(stTag[s+1])
      );
    end else begin : g_rest
      shift_stage #(
        .WIDTH(WIDTH), .TAG_W(TAG_W), .AIN_W(LVL), .LVL(LVL),
        .LVL_LO(LO), .LVL_HI(HI), .FIRST(1'b0), .REG(1'b1)
      ) u_stage (
        .clk(clk), .rst(rst), .en_i(in_ready),
        .valid_i(stVld[s]), .ext_i(stExt[s]), .sticky_i(stStk[s]),
        .amt_i(stAmt[s]), .mode_i(stMode[s]), .tag_i(stTag[s]),
        .valid_o(stVld[s+1]), .ext_o(stExt[s+1]), .sticky_o(stStk[s+1]),
        .amt_o(stAmt[s+1]), .mode_o(stMode[s+1]), .tag_o(stTag[s+1])
      );
    end
  end

  assign grsOut    = '{guard: stExt[STAGES][1], round: stExt[STAGES][0],
                       sticky: stStk[STAGES]};
  assign out_valid = stVld[STAGES];
  assign data_out  = stExt[STAGES][WIDTH+1:2];
  assign grs       = grsOut;
  assign tag_out   = stTag[STAGES];

endmodule

// File: doc/align_shifter_pipe.md
ALIGN_SHIFTER_PIPE -- requirements
Module: align_shifter_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 23, data width (mantissa).
REQ-002 SHALL have parameter SHAMT_W, default 8, shift-amount width (full exponent difference).
REQ-003 SHALL have parameter STAGES, default 2, pipeline register count; legal range 1..$clog2(WIDTH+2).
REQ-004 SHALL have parameter TAG_W, default 4, width of the pass-through tag.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 in_valid  in  1  input beat present.
REQ-008 in_ready  out  1  block accepts the beat this cycle.
REQ-009 data_in  in  WIDTH  operand.
REQ-010 shift_amount  in  SHAMT_W  unsigned shift count.
REQ-011 mode  in  2  00 LSR, 01 LSL, 10 ASR, 11 ROR.
REQ-012 tag_in  in  TAG_W  opaque tag, returned unchanged.
REQ-013 out_valid  out  1  result present.
REQ-014 out_ready  in  1  consumer accepts the result.
REQ-015 data_out  out  WIDTH  shifted result.
REQ-016 grs  out  3  {guard, round, sticky} bits lost by LSR.
REQ-017 tag_out  out  TAG_W  tag of the current result.

Function
REQ-018 A beat SHALL transfer on in_valid && in_ready; a result SHALL retire on out_valid && out_ready.
REQ-019 Latency SHALL be exactly STAGES cycles from acceptance to out_valid when never stalled.
REQ-020 in_ready SHALL equal !out_valid || out_ready; while it is low the whole pipeline SHALL hold (global stall, no bubble collapse).
REQ-021 Results SHALL emerge in acceptance order, one per cycle at full throughput; no beat is dropped or duplicated.
REQ-022 LSR: data_out = data_in >> shift_amount, zero fill; any amount >= WIDTH yields 0.
REQ-023 LSR GRS: view {data_in, 2'b00} shifted right; guard/round = the two bits immediately below the result LSB, sticky = OR of all lower lost bits; amount 0 gives 000.
REQ-024 LSL: zero fill from LSB; amount >= WIDTH yields 0; grs = 000.
REQ-025 ASR: fill with data_in[WIDTH-1]; amount >= WIDTH-1 yields all sign bits; grs = 000.
REQ-026 ROR: rotate right by shift_amount mod WIDTH; grs = 000.
REQ-027 Log levels SHALL be distributed across STAGES, with high-order amount bits (saturation) resolved in stage 1 and the result registered at the last stage.
REQ-028 data_out, grs and tag_out SHALL hold stable while out_valid && !out_ready.

Reset
REQ-029 On rst, all valid bits, data_out, grs and tag_out SHALL clear to 0 on the next edge, discarding in-flight beats.
REQ-030 in_ready SHALL be 1 in the cycle after reset deasserts; in_valid during rst SHALL be ignored.

Structure
REQ-031 Shared package fpu_shift_pkg SHALL hold the shift_mode_e enum (LSR/LSL/ASR/ROR) and the grs_t packed struct.
REQ-032 One sub-module shift_stage (parametrised level range, combinational shift plus optional register with enable) SHALL be instantiated STAGES times.

Verification (WIDTH=23, STAGES=2)
REQ-033 rst high 3 cycles -> out_valid=0, data_out=0, grs=000; in_ready=1 one cycle after release.
REQ-034 LSR 0x400001 by 1 -> 0x200000, grs=100, out_valid two cycles after accept; 0x7FFFFF by 23 -> 0x000000, grs=111; by 30 -> 0x000000, grs=001.
REQ-035 ASR 0x400000 by 4 -> 0x7C0000; by 200 -> 0x7FFFFF; LSL 0x000003 by 21 -> 0x600000.
REQ-036 ROR 0x000001 by 24 -> 0x400000; by 23 -> 0x000001.
REQ-037 Three back-to-back beats, tags 1,2,3, out_ready low 3 cycles -> in_ready drops, results held stable, then tags 1,2,3 retire in order with correct data.
REQ-038 rst asserted with two beats in flight -> out_valid=0 next cycle, neither beat ever appears; random 1000-beat run with random out_ready matches a reference model.
